ldst_ctrl: RTL and testbench
============================

# ldst_ctrl

Load/store controller between the integer unit and the 512-byte byte-addressed data RAM. It accepts one SPARC V8 load/store (op3, 9-bit address, store data) per request and translates op3 to the RAM's access-size OP code. It drives the RAM's MOV/MOC handshake, sign-extends LDSB/LDSH results, splits LDD/STD into two word accesses, and reports misalignment, illegal op3 and bus timeout as trap codes.

## Interface
Parameters:
- TIMEOUT, 15: max WAIT cycles without MOC before bus-error trap (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only in IDLE
- op3  in  6  SPARC op3 of the memory instruction
- addr  in  9  byte address
- wdata_hi  in  32  store data (rd; even reg for STD)
- wdata_lo  in  32  STD second word (rd+1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- trap  out  2  00 none, 01 misaligned, 10 illegal op3, 11 bus timeout; valid with done
- rdata_hi  out  32  load result (LDD even word)
- rdata_lo  out  32  LDD odd word
- mem_mov  out  1  RAM memory-operation-valid
- mem_rw  out  1  1 load, 0 store
- mem_addr  out  9  RAM address
- mem_din  out  32  RAM write data
- mem_op  out  6  RAM size code
- mem_moc  in  1  RAM memory-operation-complete
- mem_dout  in  32  RAM read data

## Operation
- op3 → RAM OP: LD 000000→001000; LDUB 000001→000001; LDUH 000010→000010; LDSB 001001→000001; LDSH 001010→000010; LDD 000011→001000 ×2; ST 000100→000100; STB 000101→000101; STH 000110→000110; STD 000111→000100 ×2. Any other op3 → trap 10.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0; otherwise trap 01. Byte accesses are never misaligned.
- Trapped requests issue no RAM access (mem_mov stays 0).
- Load results:
  - LDUB: {24'h0, dout[7:0]}.
  - LDSB: {{24{dout[7]}}, dout[7:0]}.
  - LDUH: {16'h0, dout[15:0]}.
  - LDSH: {{16{dout[15]}}, dout[15:0]}.
  - LD: dout → rdata_hi.
  - LDD: first word → rdata_hi, second (addr+4) → rdata_lo.
- Single loads leave rdata_lo unchanged. Stores and traps leave both rdata registers unchanged.
- STD: wdata_hi to addr, wdata_lo to addr+4. Address arithmetic is 9-bit modulo 512; an aligned double never wraps.
- op3, addr and wdata are latched on accept. Input changes while busy have no effect, and req while busy is ignored.
- FSM states:
  - IDLE: on req with a legal, aligned request → ISSUE with mem_mov=1; on req with a trap → DONE.
  - ISSUE: one cycle; mem_moc ignored because it may still be high from the previous access. → WAIT, timeout counter cleared.
  - WAIT: on mem_moc=1, capture data, mem_mov←0, → GAP if a second double access is pending, else → DONE. On counter reaching TIMEOUT: mem_mov←0, trap 11, → DONE.
  - GAP: one cycle with mem_mov=0, mem_addr←addr+4, mem_din←wdata_lo. → ISSUE with mem_mov=1.
  - DONE: done=1 with trap valid. → IDLE.
- Timeout on the first half of a double aborts the second access.

## Timing
- All outputs are registered. Reset values: busy 0, done 0, trap 00, rdata_hi/lo 0, mem_mov 0, mem_rw 1, mem_addr 0, mem_din 0, mem_op 0. State is IDLE.
- rst_n low forces the reset values immediately, including mid-access (mem_mov drops asynchronously). The RAM access in flight is abandoned.
- Edge 0 samples req. mem_mov is high after edge 1. With MOC high at its first sampled cycle, done is high in cycle 3, i.e. 3 cycles after accept.
- Double access with immediate MOC: done at 6 cycles.
- Trap 01/10: done 1 cycle after accept.
- Trap 11: done TIMEOUT+2 cycles after accept.
- mem_mov is low for at least one cycle between consecutive RAM accesses, across GAP or DONE→IDLE.
- A new req may be accepted in the cycle after done.

## Structure
- Shared package sparc_mem_pkg holds:
  - op3 constants;
  - RAM OP constants;
  - trap code constants;
  - FSM state encoding.
- One combinational sub-module, ldst_decode: op3 and addr[2:0] in; size, is_signed, is_double, is_store, ram_op, legal and aligned out.
- The FSM, counter and datapath registers stay in ldst_ctrl.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs at reset values, mem_mov 0.
- ST 0xAE910F2B at addr 0, then LD at addr 0 → mem_op 000100 then 001000; rdata_hi 0xAE910F2B; done 3 cycles after accept; trap 00.
- STH 0x0000AABB at addr 4 → mem_op 000110. LDSH 4 → rdata_hi 0xFFFFAABB. LDUH 4 → 0x0000AABB. STB 0x55 at addr 6, then LDSB 6 → 0x00000055.
- STD at addr 8 with hi 0x11223344, lo 0x55667788 → RAM accesses at 8 and 12 with mem_mov low between them. LDD 8 → rdata_hi 0x11223344, rdata_lo 0x55667788, done 6 cycles after accept.
- Traps:
  - LD at addr 2 → trap 01, done 1 cycle after accept, mem_mov never high.
  - LDD at addr 4 → trap 01.
  - op3 001111 → trap 10.
- RAM stub holds MOC low → trap 11 after TIMEOUT WAIT cycles, mem_mov drops. Separately, assert rst_n low in WAIT → mem_mov 0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC load/store path: op3 codes, RAM size codes,
// trap codes, access sizes, FSM encoding and the load-result extension helper.
package sparc_mem_pkg;

  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDD  = 6'b000011;
  localparam logic [5:0] OP3_ST   = 6'b000100;
  localparam logic [5:0] OP3_STB  = 6'b000101;
  localparam logic [5:0] OP3_STH  = 6'b000110;
  localparam logic [5:0] OP3_STD  = 6'b000111;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;

  localparam logic [5:0] RAM_OP_LD_BYTE = 6'b000001;
  localparam logic [5:0] RAM_OP_LD_HALF = 6'b000010;
  localparam logic [5:0] RAM_OP_LD_WORD = 6'b001000;
  localparam logic [5:0] RAM_OP_ST_WORD = 6'b000100;
  localparam logic [5:0] RAM_OP_ST_BYTE = 6'b000101;
  localparam logic [5:0] RAM_OP_ST_HALF = 6'b000110;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_MISALIGN = 2'b01;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b10;
  localparam logic [1:0] TRAP_BUS      = 2'b11;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_DBL  = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The RAM returns sub-word data right-justified; upper bits are don't-care.
  function automatic logic [31:0] load_extend(input size_t size, input logic is_signed,
                                              input logic [31:0] dout);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = is_signed ? {{24{dout[7]}}, dout[7:0]} : {24'h000000, dout[7:0]};
      SZ_HALF: res = is_signed ? {{16{dout[15]}}, dout[15:0]} : {16'h0000, dout[15:0]};
      default: res = dout;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ldst_decode.sv
// Combinational op3 decoder: access size, signedness, direction, RAM size code,
// legality and address alignment check.
module ldst_decode
  import sparc_mem_pkg::*;
(
  input  logic [5:0] op3,
  input  logic [2:0] addr,
  output size_t      size,
  output logic       is_signed,
  output logic       is_double,
  output logic       is_store,
  output logic [5:0] ram_op,
  output logic       legal,
  output logic       aligned
);

  // op3 to access attributes and RAM size code
  always_comb begin
    size      = SZ_WORD;
    is_signed = 1'b0;
    is_double = 1'b0;
    is_store  = 1'b0;
    ram_op    = 6'b000000;
    legal     = 1'b1;
    case (op3)
      OP3_LD:   ram_op = RAM_OP_LD_WORD;
      OP3_LDUB: begin size = SZ_BYTE; ram_op = RAM_OP_LD_BYTE; end
      OP3_LDUH: begin size = SZ_HALF; ram_op = RAM_OP_LD_HALF; end
      OP3_LDSB: begin size = SZ_BYTE; is_signed = 1'b1; ram_op = RAM_OP_LD_BYTE; end
      OP3_LDSH: begin size = SZ_HALF; is_signed = 1'b1; ram_op = RAM_OP_LD_HALF; end
      OP3_LDD:  begin size = SZ_DBL; is_double = 1'b1; ram_op = RAM_OP_LD_WORD; end
      OP3_ST:   begin is_store = 1'b1; ram_op = RAM_OP_ST_WORD; end
      OP3_STB:  begin size = SZ_BYTE; is_store = 1'b1; ram_op = RAM_OP_ST_BYTE; end
      OP3_STH:  begin size = SZ_HALF; is_store = 1'b1; ram_op = RAM_OP_ST_HALF; end
      OP3_STD:  begin size = SZ_DBL; is_double = 1'b1; is_store = 1'b1; ram_op = RAM_OP_ST_WORD; end
      default:  legal = 1'b0;
    endcase
  end

  // natural alignment for the decoded size
  always_comb begin
    aligned = 1'b1;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr[0];
      SZ_WORD: aligned = ~|addr[1:0];
      SZ_DBL:  aligned = ~|addr;
      default: aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ldst_ctrl.sv
// Load/store controller: drives the RAM MOV/MOC handshake, splits doubles into
// two word accesses, extends sub-word loads and reports trap codes.
module ldst_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [5:0]  op3,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata_hi,
  input  logic [31:0] wdata_lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  trap,
  output logic [31:0] rdata_hi,
  output logic [31:0] rdata_lo,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic [5:0]  mem_op,
  input  logic        mem_moc,
  input  logic [31:0] mem_dout
);

  state_t      state_r, state_nxt_s;
  size_t       dec_size_s, size_r;
  logic        dec_signed_s, dec_double_s, dec_store_s, dec_legal_s, dec_aligned_s;
  logic [5:0]  dec_ram_op_s;
  logic        signed_r, double_r, second_r;
  logic [31:0] wdata_lo_r;
  logic [7:0]  cnt_r;
  logic        timeout_s;

  ldst_decode u_decode (
    .op3       (op3),
    .addr      (addr[2:0]),
    .size      (dec_size_s),
    .is_signed (dec_signed_s),
    .is_double (dec_double_s),
    .is_store  (dec_store_s),
    .ram_op    (dec_ram_op_s),
    .legal     (dec_legal_s),
    .aligned   (dec_aligned_s)
  );

  assign timeout_s = (cnt_r == 8'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          if (dec_legal_s && dec_aligned_s) state_nxt_s = ST_ISSUE;
          else                              state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_moc) begin
          if (double_r && !second_r) state_nxt_s = ST_GAP;
          else                       state_nxt_s = ST_DONE;
        end else if (timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP:  state_nxt_s = ST_ISSUE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // datapath, RAM interface and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      trap       <= TRAP_NONE;
      rdata_hi   <= 32'h0000_0000;
      rdata_lo   <= 32'h0000_0000;
      mem_mov    <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= 9'h000;
      mem_din    <= 32'h0000_0000;
      mem_op     <= 6'b000000;
      size_r     <= SZ_WORD;
      signed_r   <= 1'b0;
      double_r   <= 1'b0;
      second_r   <= 1'b0;
      wdata_lo_r <= 32'h0000_0000;
      cnt_r      <= 8'h00;
    end else begin
      busy <= (state_nxt_s != ST_IDLE);
      done <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            if (!dec_legal_s) begin
              trap <= TRAP_ILLEGAL;
            end else if (!dec_aligned_s) begin
              trap <= TRAP_MISALIGN;
            end else begin
              trap       <= TRAP_NONE;
              mem_mov    <= 1'b1;
              mem_rw     <= ~dec_store_s;
              mem_addr   <= addr;
              mem_din    <= wdata_hi;
              mem_op     <= dec_ram_op_s;
              size_r     <= dec_size_s;
              signed_r   <= dec_signed_s;
              double_r   <= dec_double_s;
              second_r   <= 1'b0;
              wdata_lo_r <= wdata_lo;
            end
          end
        end
        // MOC may still be high from the previous access here, so it is ignored
        ST_ISSUE: cnt_r <= 8'h00;
        ST_WAIT: begin
          if (mem_moc) begin
            mem_mov <= 1'b0;
            if (mem_rw) begin
              if (!double_r)     rdata_hi <= load_extend(size_r, signed_r, mem_dout);
              else if (second_r) rdata_lo <= mem_dout;
              else               rdata_hi <= mem_dout;
            end
            if (double_r && !second_r) begin
              second_r <= 1'b1;
              mem_addr <= mem_addr + 9'd4;
              mem_din  <= wdata_lo_r;
            end
          end else if (timeout_s) begin
            mem_mov <= 1'b0;
            trap    <= TRAP_BUS;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_GAP:  mem_mov <= 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ldst_ctrl.sv
// Directed bench for ldst_ctrl with a byte-addressed big-endian RAM stub.
module tb_ldst_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [5:0]  op3;
  logic [8:0]  addr;
  logic [31:0] wdata_hi, wdata_lo;
  logic        busy, done;
  logic [1:0]  trap;
  logic [31:0] rdata_hi, rdata_lo;
  logic        mem_mov, mem_rw;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [5:0]  mem_op;
  logic        mem_moc;
  logic [31:0] mem_dout;

  int errors = 0;
  int checks = 0;

  ldst_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op3(op3), .addr(addr),
    .wdata_hi(wdata_hi), .wdata_lo(wdata_lo), .busy(busy), .done(done),
    .trap(trap), .rdata_hi(rdata_hi), .rdata_lo(rdata_lo),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_op(mem_op), .mem_moc(mem_moc), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // RAM stub: answers one cycle after it sees MOV, drops MOC once MOV falls
  logic [7:0] ram [0:511];
  logic       stub_on;

  always @(posedge clk) begin
    if (mem_mov && !mem_moc && stub_on) begin
      case (mem_op)
        6'b000100: begin
          ram[mem_addr]         <= mem_din[31:24];
          ram[mem_addr + 9'd1]  <= mem_din[23:16];
          ram[mem_addr + 9'd2]  <= mem_din[15:8];
          ram[mem_addr + 9'd3]  <= mem_din[7:0];
        end
        6'b000110: begin
          ram[mem_addr]         <= mem_din[15:8];
          ram[mem_addr + 9'd1]  <= mem_din[7:0];
        end
        6'b000101: ram[mem_addr] <= mem_din[7:0];
        6'b001000: mem_dout <= {ram[mem_addr], ram[mem_addr + 9'd1],
                                ram[mem_addr + 9'd2], ram[mem_addr + 9'd3]};
        6'b000010: mem_dout <= {16'hDEAD, ram[mem_addr], ram[mem_addr + 9'd1]};
        6'b000001: mem_dout <= {24'hC0FFEE, ram[mem_addr]};
        default:   mem_dout <= 32'hBAD0_BAD0;
      endcase
      mem_moc <= 1'b1;
    end else if (!mem_mov) begin
      mem_moc <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // results of the last transaction
  int          lat;
  int          nacc;
  logic [1:0]  trap_s;
  logic        mov_c1;
  logic [8:0]  acc_addr [2];
  logic [5:0]  acc_op [2];

  task automatic do_op(input logic [5:0] o, input logic [8:0] a,
                       input logic [31:0] hi, input logic [31:0] lo);
    logic prev;
    logic got_done;
    @(negedge clk);
    req = 1'b1; op3 = o; addr = a; wdata_hi = hi; wdata_lo = lo;
    @(posedge clk); #1;
    req = 1'b0; op3 = 6'b111111; addr = 9'h1FF; wdata_hi = 32'hFFFF_FFFF; wdata_lo = 32'h0;
    lat = 0; nacc = 0; prev = 1'b0; mov_c1 = 1'b0; got_done = 1'b0; trap_s = 2'b00;
    for (int k = 0; k < 100; k++) begin
      if (k == 1) mov_c1 = mem_mov;
      if (mem_mov && !prev) begin
        if (nacc < 2) begin
          acc_addr[nacc] = mem_addr;
          acc_op[nacc]   = mem_op;
        end
        nacc++;
      end
      prev = mem_mov;
      if (done) begin
        got_done = 1'b1;
        trap_s   = trap;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    stub_on = 1'b1; mem_moc = 1'b0; mem_dout = 32'h0;

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 1'($urandom); op3 = 6'($urandom); addr = 9'($urandom);
      wdata_hi = $urandom; wdata_lo = $urandom;
    end
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_trap", {30'd0, trap}, 32'd0);
    check("rst_rdata_hi", rdata_hi, 32'd0);
    check("rst_rdata_lo", rdata_lo, 32'd0);
    check("rst_mem_mov", {31'd0, mem_mov}, 32'd0);
    check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
    check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_mem_op", {26'd0, mem_op}, 32'd0);
    @(negedge clk); req = 1'b0; rst_n = 1'b1;

    // ST then LD word
    do_op(6'b000100, 9'd0, 32'hAE91_0F2B, 32'h0);
    check("st_op", {26'd0, acc_op[0]}, 32'h04);
    check("st_lat", lat, 32'd3);
    check("st_trap", {30'd0, trap_s}, 32'd0);
    do_op(6'b000000, 9'd0, 32'h0, 32'h0);
    check("ld_op", {26'd0, acc_op[0]}, 32'h08);
    check("ld_data", rdata_hi, 32'hAE91_0F2B);
    check("ld_lat", lat, 32'd3);
    check("ld_trap", {30'd0, trap_s}, 32'd0);
    check("ld_mov_c1", {31'd0, mov_c1}, 32'd1);
    check("ld_lo_kept", rdata_lo, 32'd0);

    // halfword / byte stores and extending loads
    do_op(6'b000110, 9'd4, 32'h0000_AABB, 32'h0);
    check("sth_op", {26'd0, acc_op[0]}, 32'h06);
    check("sth_hi_kept", rdata_hi, 32'hAE91_0F2B);
    do_op(6'b001010, 9'd4, 32'h0, 32'h0);
    check("ldsh", rdata_hi, 32'hFFFF_AABB);
    do_op(6'b000010, 9'd4, 32'h0, 32'h0);
    check("lduh", rdata_hi, 32'h0000_AABB);
    do_op(6'b000001, 9'd4, 32'h0, 32'h0);
    check("ldub", rdata_hi, 32'h0000_00AA);
    do_op(6'b001001, 9'd4, 32'h0, 32'h0);
    check("ldsb_neg", rdata_hi, 32'hFFFF_FFAA);
    do_op(6'b000101, 9'd6, 32'h0000_0055, 32'h0);
    check("stb_op", {26'd0, acc_op[0]}, 32'h05);
    do_op(6'b001001, 9'd6, 32'h0, 32'h0);
    check("ldsb_pos", rdata_hi, 32'h0000_0055);
    do_op(6'b000001, 9'd3, 32'h0, 32'h0);
    check("ldub_odd_trap", {30'd0, trap_s}, 32'd0);
    check("ldub_odd", rdata_hi, 32'h0000_002B);

    // double store / load
    do_op(6'b000111, 9'd8, 32'h1122_3344, 32'h5566_7788);
    check("std_nacc", nacc, 32'd2);
    check("std_addr0", {23'd0, acc_addr[0]}, 32'd8);
    check("std_addr1", {23'd0, acc_addr[1]}, 32'd12);
    check("std_op1", {26'd0, acc_op[1]}, 32'h04);
    check("std_lat", lat, 32'd6);
    do_op(6'b000011, 9'd8, 32'h0, 32'h0);
    check("ldd_hi", rdata_hi, 32'h1122_3344);
    check("ldd_lo", rdata_lo, 32'h5566_7788);
    check("ldd_lat", lat, 32'd6);
    check("ldd_op0", {26'd0, acc_op[0]}, 32'h08);

    // traps
    do_op(6'b000000, 9'd2, 32'h0, 32'h0);
    check("ld2_trap", {30'd0, trap_s}, 32'd1);
    check("ld2_lat", lat, 32'd1);
    check("ld2_nacc", nacc, 32'd0);
    check("ld2_hi_kept", rdata_hi, 32'h1122_3344);
    do_op(6'b000011, 9'd4, 32'h0, 32'h0);
    check("ldd4_trap", {30'd0, trap_s}, 32'd1);
    check("ldd4_nacc", nacc, 32'd0);
    do_op(6'b000110, 9'd1, 32'h0, 32'h0);
    check("sth1_trap", {30'd0, trap_s}, 32'd1);
    do_op(6'b001111, 9'd0, 32'h0, 32'h0);
    check("ill_trap", {30'd0, trap_s}, 32'd2);
    check("ill_lat", lat, 32'd1);
    check("ill_nacc", nacc, 32'd0);

    // bus timeout
    stub_on = 1'b0;
    do_op(6'b000000, 9'd0, 32'h0, 32'h0);
    check("tmo_trap", {30'd0, trap_s}, 32'd3);
    check("tmo_lat", lat, TMO + 2);
    check("tmo_mov", {31'd0, mem_mov}, 32'd0);
    check("tmo_hi_kept", rdata_hi, 32'h1122_3344);

    // asynchronous reset during WAIT
    @(negedge clk);
    req = 1'b1; op3 = 6'b000000; addr = 9'd0;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wait_mov", {31'd0, mem_mov}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mov", {31'd0, mem_mov}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rdata", rdata_hi, 32'd0);
    @(negedge clk); rst_n = 1'b1; stub_on = 1'b1;
    do_op(6'b000000, 9'd0, 32'h0, 32'h0);
    check("post_rst_lat", lat, 32'd3);
    check("post_rst_ld", rdata_hi, 32'hAE91_0F2B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
